// File: rtl/pcss_link_rx_axis.sv
// Chip-link receive packer: 4 x 16-bit link words -> 64-bit AXIS beats.
// Parity checking is compiled in only when PCSS_RX_PARITY_EN is defined.
module pcss_link_rx_axis #(
  parameter int CHIPDATA_WIDTH = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int FIFO_DEPTH     = 16,
  parameter int IDLE_TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] link_data_in,
  input  logic                      link_valid_in,
  input  logic                      link_par_in,
  output logic                      link_ready_out,
  output logic                      link_err_out,
  output logic [DATA_WIDTH-1:0]     M_AXIS_recv_tdata,
  output logic                      M_AXIS_recv_tvalid,
  output logic                      M_AXIS_recv_tlast,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_recv_tkeep,
  input  logic                      M_AXIS_recv_tready,
  output logic [15:0]               err_count,
  output logic [31:0]               beat_count
);

  localparam int LANES = DATA_WIDTH / CHIPDATA_WIDTH;
  localparam int KW    = DATA_WIDTH / 8;
  localparam int LB    = CHIPDATA_WIDTH / 8;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NW    = $clog2(LANES);
  localparam int EW    = DATA_WIDTH + KW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic                  ready_q;
  logic                  accept;
  logic                  bad;
  logic                  good;
  logic                  last_word;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] pack_q;
  logic [DATA_WIDTH-1:0] pack_ins;
  logic [NW-1:0]         nwords_q;
  logic [15:0]           idle_q;

  logic                  stg_vld_q;
  logic [DATA_WIDTH-1:0] stg_data_q;
  logic [KW-1:0]         stg_keep_q;
  logic                  stg_last_q;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [EW-1:0]         head;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count_q;
  logic                  wr_en;
  logic                  rd_en;
  logic                  full;
  logic                  tvalid;
  logic [31:0]           beat_q;

  function automatic logic [KW-1:0] keep_of(input logic [NW-1:0] n);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(n)) k[i*LB +: LB] = '1;
    end
    return k;
  endfunction

  assign accept    = link_valid_in && ready_q;
  assign good      = accept && !bad;
  assign last_word = good && (nwords_q == NW'(LANES - 1));
  assign timeout   = (state_q == FILL) && !accept &&
                     (idle_q == 16'(IDLE_TIMEOUT - 1));

  always_comb begin
    pack_ins = pack_q;
    pack_ins[nwords_q*CHIPDATA_WIDTH +: CHIPDATA_WIDTH] = link_data_in;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (good) state_d = FILL;
      FILL: begin
        if (last_word)    state_d = EMPTY;
        else if (timeout) state_d = FLUSH;
      end
      FLUSH:   state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Completed or flushed beats pass through one staging register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      pack_q     <= '0;
      nwords_q   <= '0;
      idle_q     <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      stg_keep_q <= '0;
      stg_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stg_vld_q <= 1'b0;
      if (last_word) begin
        stg_vld_q  <= 1'b1;
        stg_data_q <= pack_ins;
        stg_keep_q <= '1;
        stg_last_q <= 1'b0;
        pack_q     <= '0;
        nwords_q   <= '0;
      end else if (good) begin
        pack_q   <= pack_ins;
        nwords_q <= nwords_q + 1'b1;
      end else if (state_q == FLUSH) begin
        stg_vld_q  <= 1'b1;
        stg_data_q <= pack_q;
        stg_keep_q <= keep_of(nwords_q);
        stg_last_q <= 1'b1;
        pack_q     <= '0;
        nwords_q   <= '0;
      end
      if (accept || state_q != FILL) idle_q <= '0;
      else                           idle_q <= idle_q + 1'b1;
    end
  end

  assign wr_en  = stg_vld_q;
  assign tvalid = (count_q != '0);
  assign rd_en  = tvalid && M_AXIS_recv_tready;
  assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {stg_last_q, stg_keep_q, stg_data_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ready_q <= (count_q <= (AW+1)'(FIFO_DEPTH - 2)) &&
                 (state_d != FLUSH);
      if (rd_en) beat_q <= beat_q + 1'b1;
    end
  end

`ifdef PCSS_RX_PARITY_EN
  logic        err_q;
  logic [15:0] err_cnt_q;

  assign bad = ^{link_data_in, link_par_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= accept && bad;
      if (accept && bad && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign link_err_out = err_q;
  assign err_count    = err_cnt_q;
`else
  logic unused_par;

  assign unused_par   = link_par_in;
  assign bad          = 1'b0;
  assign link_err_out = 1'b0;
  assign err_count    = '0;
`endif

  assign link_ready_out     = ready_q;
  assign M_AXIS_recv_tvalid = tvalid;
  assign M_AXIS_recv_tdata  = tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign M_AXIS_recv_tkeep  = tvalid ? head[DATA_WIDTH +: KW] : '0;
  assign M_AXIS_recv_tlast  = tvalid && head[EW-1];
  assign beat_count         = beat_q;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(wr_en && full)
  );

endmodule
